er_metric_accum: RTL

ER_METRIC_ACCUM -- requirements
Module: er_metric_accum

---
 rtl/er_metric_accum_pkg.sv | 16 +
 rtl/er_metric_accum_abs_diff.sv | 16 +
 rtl/er_metric_accum.sv | 116 +++++++++++
 3 files changed

// File: rtl/er_metric_accum_pkg.sv
// Shared definitions for the approximate-adder error-metric accumulator.
// Holds the run-control FSM state encoding and the default widths used by
// er_metric_accum when it is instantiated without overrides.
package er_metric_accum_pkg;

   localparam int DEF_N     = 16;  // operand/sum width of the adder under test
   localparam int DEF_CNT_W = 32;  // sample counter width

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/er_metric_accum_abs_diff.sv
// Combinational N-bit unsigned absolute difference |a - b|.
// The subtraction is ordered so the result never wraps.
// Ports:
//   a, b : N-bit unsigned operands
//   d    : N-bit |a - b|
module abs_diff #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] d
);

   assign d = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/er_metric_accum.sv
// Error-metric accumulator for characterising an approximate adder.
// A run is started with a one-cycle start pulse; num_samples pairs of
// (approx_s, exact_s) are accepted over a valid/ready handshake, pushed through
// a two-stage pipeline (distance compute, then accumulate) and summarised as
// error count, sum/max of error distance and count of exact==0 samples.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start, num_samples   : run start pulse and sample count (latched on start)
//   in_valid, in_ready   : input pair handshake
//   approx_s, exact_s    : approximate and exact N-bit sums
//   busy, done           : run in progress (RUN/DRAIN), end-of-run pulse
//   err_count, sum_ed, max_ed, zero_exact, sample_count : results
module er_metric_accum
   import er_metric_accum_pkg::*;
#(
   parameter  int N     = DEF_N,
   parameter  int CNT_W = DEF_CNT_W,
   localparam int SUM_W = N + CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     approx_s,
   input  logic [N-1:0]     exact_s,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [SUM_W-1:0] sum_ed,
   output logic [N-1:0]     max_ed,
   output logic [CNT_W-1:0] zero_exact,
   output logic [CNT_W-1:0] sample_count
);

   state_t           state, state_nx;
   logic [CNT_W-1:0] num_lat;
   logic             accept;
   logic             last_accept;
   logic [2:1]       vld_pipe;     // [1]: stage-1 regs valid, [2]: stage-2 update just done
   logic [N-1:0]     ed;
   logic [N-1:0]     ed_q;
   logic             mis_q;
   logic             zero_q;

   abs_diff #(.N(N)) u_abs_diff (
      .a (approx_s),
      .b (exact_s),
      .d (ed)
   );

   assign in_ready    = (state == ST_RUN) && (sample_count < num_lat);
   assign accept      = in_valid && in_ready;
   assign last_accept = accept && ((sample_count + CNT_W'(1)) == num_lat);
   assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
   assign done        = (state == ST_DONE);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start) state_nx = (num_samples == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (last_accept) state_nx = ST_DRAIN;
         ST_DRAIN: if (vld_pipe == 2'b00) state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         num_lat      <= '0;
         vld_pipe     <= '0;
         ed_q         <= '0;
         mis_q        <= 1'b0;
         zero_q       <= 1'b0;
         err_count    <= '0;
         sum_ed       <= '0;
         max_ed       <= '0;
         zero_exact   <= '0;
         sample_count <= '0;
      end else begin
         state    <= state_nx;
         vld_pipe <= {vld_pipe[1], accept};

         // stage 1: per-pair metrics, captured only on accept so input data
         // need not be held by the source
         if (accept) begin
            ed_q   <= ed;
            mis_q  <= (approx_s != exact_s);
            zero_q <= (exact_s == '0);
         end

         if (state == ST_IDLE && start) begin
            // a new run starts from clean results; the pipeline is empty here
            num_lat      <= num_samples;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
            zero_exact   <= '0;
            sample_count <= '0;
         end else begin
            if (accept) sample_count <= sample_count + CNT_W'(1);
            // stage 2: accumulate; ties on max keep the earlier value
            if (vld_pipe[1]) begin
               err_count  <= err_count + CNT_W'(mis_q);
               sum_ed     <= sum_ed + SUM_W'(ed_q);
               zero_exact <= zero_exact + CNT_W'(zero_q);
               if (ed_q > max_ed) max_ed <= ed_q;
            end
         end
      end
   end

endmodule
